// File: rtl/spi_cmd_queue_if.sv
// Bus/SPI-side signal bundle for spi_cmd_queue.
// Handshakes: wren is a one-cycle write strobe with no ready. full and ovf are
// status only, and a write while full is dropped. ctrlen is a fixed-length
// strobe with no back-pressure. spi_busy only gates the start of a new command.
interface spi_cmd_queue_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
);
  logic                     wren;
  logic [31:0]              indata;
  logic                     spi_busy;
  logic                     full;
  logic                     ovf;
  logic [$clog2(DEPTH):0]   pending;
  logic                     ctrlen;
  logic [ADDR_W-1:0]        addr;
  logic [DATA_W-1:0]        sdata;
  logic [CNT_W-1:0]         cntmon;
  logic [1:0]               fsm_state;

  modport master (
    output wren, indata, spi_busy,
    input  full, ovf, pending, ctrlen, addr, sdata, cntmon, fsm_state
  );

  modport slave (
    input  wren, indata, spi_busy,
    output full, ovf, pending, ctrlen, addr, sdata, cntmon, fsm_state
  );
endinterface

// File: rtl/spi_cmd_queue.sv
// FIFO-backed SPI command issuer with a programmable-length ctrlen strobe.
// Optional macro SPI_CMDQ_DEDUP_EN drops writes equal to the last accepted word.
module spi_cmd_queue #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 4,
  parameter int STROBE_LEN = 5,
  parameter int CNT_W      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_cmd_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CMD_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STROBE_LEN - 1);
  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, GAP = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CMD_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count_q;
  logic               ovf_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  sdata_q;
  logic               pop, push, dup, full;
  logic               unused_indata;

  assign unused_indata = ^bus.indata;
  assign full          = (count_q == COUNT_FULL);

`ifdef SPI_CMDQ_DEDUP_EN
  logic [31:0] last_q;
  assign dup = (bus.indata == last_q);
`else
  assign dup = 1'b0;
`endif

  // full is the registered occupancy, so a same-cycle pop never frees a slot for this write
  assign push = bus.wren && !full && !dup;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0 && !bus.spi_busy) begin
          pop     = 1'b1;
          cnt_d   = '0;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ctrlen    = (state_q == STROBE);
    bus.cntmon    = cnt_q;
    bus.fsm_state = state_q;
    bus.full      = full;
    bus.ovf       = ovf_q;
    bus.pending   = count_q;
    bus.addr      = addr_q;
    bus.sdata     = sdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      addr_q  <= '0;
      sdata_q <= '1;
`ifdef SPI_CMDQ_DEDUP_EN
      last_q  <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        addr_q  <= mem[rd_ptr][CMD_W-1:DATA_W];
        sdata_q <= mem[rd_ptr][DATA_W-1:0];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (bus.wren && full && !dup) ovf_q <= 1'b1;
`ifdef SPI_CMDQ_DEDUP_EN
      if (push) last_q <= bus.indata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.indata[CMD_W-1:0];
  end
endmodule
